uart_cmd_ctrl: RTL and testbench

Command-frame controller sitting directly behind the UART receive driver in the car's control path. It consumes received bytes and assembles fixed 5-byte command frames, validates them, and presents decoded commands to the motion and peripheral logic. It owns the receiver's configuration: it drives the receive enable, and it sequences runtime baud-rate changes through the receiver's set-baudrate edge input.

---
 rtl/uart_cmd_pkg.sv | 24 ++
 rtl/uart_gap_timer.sv | 17 +
 rtl/uart_cmd_ctrl.sv | 109 ++++++++++
 tb/tb_uart_cmd_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared FSM states, frame constants and baud-table lookup
package uart_cmd_pkg;
    typedef enum logic [2:0] {
        IDLE, GET_CMD, GET_AH, GET_AL, GET_CHK, BAUD_DIS, BAUD_SET, BAUD_SETTLE
    } state_t;

    localparam logic [7:0] HDR = 8'hA5;
    localparam logic [7:0] CMD_SET_BAUD = 8'hB0;

    typedef struct packed {
        logic        ok;
        logic [30:0] rate;
    } baud_t;

    function automatic baud_t baud_lookup(input logic [2:0] idx);
        baud_t b;
        b.ok = idx <= 3'd4;
        b.rate = idx == 3'd0 ? 31'd9600 :
                 idx == 3'd1 ? 31'd19200 :
                 idx == 3'd2 ? 31'd38400 :
                 idx == 3'd3 ? 31'd57600 : 31'd115200;
        return b;
    endfunction
endpackage

// File: rtl/uart_gap_timer.sv
// uart_gap_timer: counts idle cycles while enabled, strobes tc on the cycle the limit is reached
module uart_gap_timer #(
    parameter int LIMIT = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else       cnt <= (clr || !en) ? '0 : cnt + 1'b1;
    assign tc = en && cnt == W'(LIMIT - 1);
endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: assembles and validates 5-byte UART command frames, sequences
// runtime baud-rate changes of the receiver
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 125_000_000,
    parameter int GAP_TIMEOUT_US = 2000,
    parameter int SET_HOLD_CYC   = 4,
    parameter int SETTLE_CYC     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_rq,
    output logic        en_rx,
    output logic        set_baudrate,
    output logic [30:0] baudrate,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic [15:0] cmd_arg,
    output logic        frame_err,
    output logic [7:0]  err_cnt
);
    localparam int GAP_CYC = CLK_FREQ_HZ / 1_000_000 * GAP_TIMEOUT_US;
    localparam int CW = $clog2((SET_HOLD_CYC > SETTLE_CYC ? SET_HOLD_CYC : SETTLE_CYC) + 1);

    state_t        state;
    logic [7:0]    cmd_b, ah, al;
    logic [CW-1:0] cnt;
    logic          in_frame, tc, baud_ok;
    baud_t         lk;

    assign in_frame = state inside {GET_CMD, GET_AH, GET_AL, GET_CHK};
    assign lk = baud_lookup(al[2:0]);
    assign baud_ok = lk.ok && al[7:3] == 5'd0;

    uart_gap_timer #(.LIMIT(GAP_CYC)) u_gap (
        .clk(clk), .reset(reset), .clr(rx_rq), .en(in_frame), .tc(tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cmd_b        <= '0;
            ah           <= '0;
            al           <= '0;
            cnt          <= '0;
            en_rx        <= 1'b1;
            set_baudrate <= 1'b0;
            baudrate     <= 31'd115200;
            cmd_valid    <= 1'b0;
            cmd_code     <= '0;
            cmd_arg      <= '0;
            frame_err    <= 1'b0;
            err_cnt      <= '0;
        end else begin
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            // a byte arriving on the expiry cycle takes priority over the timeout
            if (in_frame && tc && !rx_rq) begin
                frame_err <= 1'b1;
                err_cnt   <= err_cnt + 8'(err_cnt != 8'hFF);
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE:    if (rx_rq && rx_data == HDR) state <= GET_CMD;
                    GET_CMD: if (rx_rq) begin cmd_b <= rx_data; state <= GET_AH; end
                    GET_AH:  if (rx_rq) begin ah <= rx_data; state <= GET_AL; end
                    GET_AL:  if (rx_rq) begin al <= rx_data; state <= GET_CHK; end
                    GET_CHK: if (rx_rq) begin
                        state <= IDLE;
                        if (rx_data != (cmd_b ^ ah ^ al) || (cmd_b == CMD_SET_BAUD && !baud_ok)) begin
                            frame_err <= 1'b1;
                            err_cnt   <= err_cnt + 8'(err_cnt != 8'hFF);
                        end else if (cmd_b != CMD_SET_BAUD) begin
                            cmd_valid <= 1'b1;
                            cmd_code  <= cmd_b;
                            cmd_arg   <= {ah, al};
                        end else begin
                            baudrate <= lk.rate;
                            en_rx    <= 1'b0;
                            state    <= BAUD_DIS;
                        end
                    end
                    BAUD_DIS: begin
                        set_baudrate <= 1'b1;
                        cnt          <= '0;
                        state        <= BAUD_SET;
                    end
                    BAUD_SET: begin
                        cnt <= cnt == CW'(SET_HOLD_CYC - 1) ? '0 : cnt + 1'b1;
                        if (cnt == CW'(SET_HOLD_CYC - 1)) begin
                            set_baudrate <= 1'b0;
                            state        <= BAUD_SETTLE;
                        end
                    end
                    BAUD_SETTLE: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(SETTLE_CYC - 1)) begin
                            en_rx <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed and random frames checked against a frame-level reference model
module tb_uart_cmd_ctrl;
    localparam int H = 4;
    localparam int S = 16;
    localparam int GAP = 250;

    logic        clk = 0, reset = 1, rx_rq = 0;
    logic [7:0]  rx_data = 0;
    logic        en_rx, set_baudrate, cmd_valid, frame_err;
    logic [30:0] baudrate;
    logic [7:0]  cmd_code, err_cnt;
    logic [15:0] cmd_arg;

    int checks = 0, errors = 0;
    int n_valid = 0, n_err = 0, en_low = 0, set_hi = 0;
    int rates[5] = '{9600, 19200, 38400, 57600, 115200};
    int exp_baud = 115200, exp_errcnt = 0;
    logic [7:0]  exp_code = 0;
    logic [15:0] exp_arg = 0;

    uart_cmd_ctrl #(.GAP_TIMEOUT_US(2), .SET_HOLD_CYC(H), .SETTLE_CYC(S)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_rq(rx_rq),
        .en_rx(en_rx), .set_baudrate(set_baudrate), .baudrate(baudrate),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_arg(cmd_arg),
        .frame_err(frame_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid) n_valid++;
        if (frame_err) n_err++;
        if (!en_rx) en_low++;
        if (set_baudrate) set_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_rq = 1;
        @(negedge clk);
        rx_rq = 0;
    endtask

    task automatic do_frame(input logic [39:0] f, input bit rand_gap);
        int sv, se, sl, sh, e_valid, e_err, e_low, e_hi;
        logic [7:0] c, h, l, k;
        c = f[31:24]; h = f[23:16]; l = f[15:8]; k = f[7:0];
        e_valid = 0; e_err = 0; e_low = 0; e_hi = 0;
        if (f[39:32] != 8'hA5) ;
        else if (k != (c ^ h ^ l)) e_err = 1;
        else if (c != 8'hB0) begin e_valid = 1; exp_code = c; exp_arg = {h, l}; end
        else if (l > 4) e_err = 1;
        else begin exp_baud = rates[l]; e_low = 1 + H + S; e_hi = H; end
        exp_errcnt = exp_errcnt + e_err > 255 ? 255 : exp_errcnt + e_err;
        sv = n_valid; se = n_err; sl = en_low; sh = set_hi;
        for (int i = 0; i < 5; i++) begin
            send_byte(f[39-8*i -: 8]);
            if (rand_gap && i < 4) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        // bytes landing in the baud sequence must be dropped
        if (e_hi != 0) begin send_byte(8'hA5); send_byte(8'h10); end
        repeat (30) @(negedge clk);
        chk("valid_cnt", n_valid - sv, e_valid);
        chk("err_pulses", n_err - se, e_err);
        chk("cmd_code", cmd_code, exp_code);
        chk("cmd_arg", cmd_arg, exp_arg);
        chk("baudrate", baudrate, exp_baud);
        chk("err_cnt", err_cnt, exp_errcnt);
        chk("en_rx_low_cycles", en_low - sl, e_low);
        chk("set_baud_cycles", set_hi - sh, e_hi);
        chk("en_rx_final", en_rx, 1);
    endtask

    initial begin
        int se, sv;
        logic [7:0] c, h, l;
        #12 reset = 0;
        @(negedge clk);
        chk("rst_en_rx", en_rx, 1);
        chk("rst_set_baud", set_baudrate, 0);
        chk("rst_baud", baudrate, 115200);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_code", cmd_code, 0);
        chk("rst_arg", cmd_arg, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_errcnt", err_cnt, 0);

        do_frame(40'hA5_10_01_F4_E5, 0);
        do_frame(40'hA5_10_01_F4_00, 0);
        do_frame(40'hA5_B0_00_01_B1, 0);
        do_frame(40'hA5_B0_00_07_B7, 0);
        do_frame(40'hA5_B0_00_04_B4, 1);
        do_frame(40'hA5_A5_A5_01_01, 1);
        do_frame(40'h33_10_01_F4_E5, 0);

        se = n_err;
        send_byte(8'hA5); send_byte(8'h10);
        repeat (GAP + 50) @(negedge clk);
        exp_errcnt++;
        chk("timeout_err", n_err - se, 1);
        do_frame(40'hA5_20_00_00_20, 0);

        sv = n_valid; se = n_err;
        send_byte(8'hA5); send_byte(8'h30);
        repeat (GAP - 60) @(negedge clk);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h30);
        repeat (5) @(negedge clk);
        chk("near_timeout_err", n_err - se, 0);
        chk("near_timeout_valid", n_valid - sv, 1);
        chk("near_timeout_code", cmd_code, 8'h30);
        exp_code = 8'h30; exp_arg = 16'h0000;

        for (int n = 0; n < 16; n++) begin
            c = $urandom_range(0, 3) == 0 ? 8'hB0 : 8'($urandom);
            h = 8'($urandom);
            l = c == 8'hB0 ? 8'($urandom_range(0, 7)) : 8'($urandom);
            do_frame({8'hA5, c, h, l, $urandom_range(0, 3) == 0 ? 8'($urandom) : c ^ h ^ l}, 1);
        end

        send_byte(8'hA5); send_byte(8'hB0); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hB1);
        repeat (3) @(negedge clk);
        chk("pre_rst_set_baud", set_baudrate, 1);
        reset = 1;
        #1;
        chk("arst_set_baud", set_baudrate, 0);
        chk("arst_en_rx", en_rx, 1);
        chk("arst_baud", baudrate, 115200);
        chk("arst_errcnt", err_cnt, 0);
        @(negedge clk);
        reset = 0;
        exp_baud = 115200; exp_errcnt = 0; exp_code = 0; exp_arg = 0;
        repeat (2) @(negedge clk);
        do_frame(40'hA5_42_12_34_64, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
